// File: rtl/bdu_pkg.sv
// Shared constants and FSM state type for the bit-serial distance path.
package bdu_pkg;

    localparam int B = 32;

    localparam logic [1:0] CODE_X = 2'b01;
    localparam logic [1:0] CODE_Y = 2'b10;
    localparam logic [1:0] CODE_Z = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bser_bit_select.sv
// Maps stream index k to (plane p, dimension d) and selects the matching
// coordinate bits, MSB plane first, interleaving x/y/z within each plane.
module bser_bit_select #(
    parameter int B  = 32,
    parameter int KW = $clog2(3*B+1),
    parameter int BW = $clog2(B)
) (
    input  logic          en,
    input  logic [KW-1:0] k,
    input  logic [B-1:0]  q_x,
    input  logic [B-1:0]  q_y,
    input  logic [B-1:0]  q_z,
    input  logic [B-1:0]  r_x,
    input  logic [B-1:0]  r_y,
    input  logic [B-1:0]  r_z,
    output logic          q_bit,
    output logic          r_bit,
    output logic [1:0]    code,
    output logic [BW-1:0] b
);
    import bdu_pkg::*;

    logic [KW-1:0] p;
    logic [KW-1:0] d;
    logic [BW-1:0] idx;

    always_comb begin
        p     = k / KW'(3);
        d     = k - p * KW'(3);
        idx   = BW'(B - 1) - p[BW-1:0];
        q_bit = 1'b0;
        r_bit = 1'b0;
        code  = 2'b00;
        b     = '0;
        if (en) begin
            // b counts planes from 1; the LSB plane (b=B) wraps to 0
            b = p[BW-1:0] + BW'(1);
            case (d)
                KW'(0): begin
                    code  = CODE_X;
                    q_bit = q_x[idx];
                    r_bit = r_x[idx];
                end
                KW'(1): begin
                    code  = CODE_Y;
                    q_bit = q_y[idx];
                    r_bit = r_y[idx];
                end
                default: begin
                    code  = CODE_Z;
                    q_bit = q_z[idx];
                    r_bit = r_z[idx];
                end
            endcase
        end
    end

endmodule

// File: rtl/point_serializer.sv
// Loads a query/reference point pair and streams their bits to the distance
// unit, then reports selected/pruned. Optional stall input: BSER_STALL_EN.
module point_serializer #(
    parameter int B = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [B-1:0]         q_x,
    input  logic [B-1:0]         q_y,
    input  logic [B-1:0]         q_z,
    input  logic [B-1:0]         r_x,
    input  logic [B-1:0]         r_y,
    input  logic [B-1:0]         r_z,
    output logic                 valid,
    output logic                 q_bit,
    output logic                 r_bit,
    output logic [1:0]           code,
    output logic [$clog2(B)-1:0] b,
    input  logic                 terminate,
    input  logic                 done,
`ifdef BSER_STALL_EN
    input  logic                 stall,
`endif
    output logic                 ref_selected,
    output logic                 ref_pruned,
    output logic                 busy
);
    import bdu_pkg::*;

    localparam int KW   = $clog2(3*B+1);
    localparam int LAST = 3*B - 1;

    state_t          state_q, state_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [6*B-1:0]  pt_q, pt_d;
    logic            sel_q, sel_d;
    logic            pruned_q, pruned_d;
    logic            stall_w;

`ifdef BSER_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pt_q     <= '0;
            sel_q    <= 1'b0;
            pruned_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
            sel_q    <= sel_d;
            pruned_q <= pruned_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pt_d     = pt_q;
        sel_d    = 1'b0;
        pruned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pt_d    = {r_z, r_y, r_x, q_z, q_y, q_x};
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (terminate) begin
                    pruned_d = 1'b1;
                    state_d  = IDLE;
                end else if (!stall_w) begin
                    // counter parks on the last index so it never wraps
                    if (cnt_q == KW'(LAST)) state_d = WAIT_DONE;
                    else                    cnt_d   = cnt_q + KW'(1);
                end
            end
            WAIT_DONE: begin
                if (terminate) begin
                    pruned_d = 1'b1;
                    state_d  = IDLE;
                end else if (!stall_w && done) begin
                    sel_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign valid        = (state_q == STREAM) && !stall_w;
    assign ref_selected = sel_q;
    assign ref_pruned   = pruned_q;

    bser_bit_select #(.B(B), .KW(KW), .BW($clog2(B))) u_bit_select (
        .en    (valid),
        .k     (cnt_q),
        .q_x   (pt_q[0*B +: B]),
        .q_y   (pt_q[1*B +: B]),
        .q_z   (pt_q[2*B +: B]),
        .r_x   (pt_q[3*B +: B]),
        .r_y   (pt_q[4*B +: B]),
        .r_z   (pt_q[5*B +: B]),
        .q_bit (q_bit),
        .r_bit (r_bit),
        .code  (code),
        .b     (b)
    );

endmodule

// File: tb/tb_point_serializer.sv
// Self-checking bench for point_serializer: table of points plus random points,
// each stream checked against a per-index bit model.
module tb_point_serializer;
    localparam int B  = 32;
    localparam int N  = 3*B;
    localparam int BW = $clog2(B);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          terminate = 1'b0;
    logic          done = 1'b0;
`ifdef BSER_STALL_EN
    logic          stall = 1'b0;
`endif
    logic [B-1:0]  q_x = '0, q_y = '0, q_z = '0, r_x = '0, r_y = '0, r_z = '0;
    logic          in_ready, valid, q_bit, r_bit, ref_selected, ref_pruned, busy;
    logic [1:0]    code;
    logic [BW-1:0] b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    point_serializer #(.B(B)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .q_x          (q_x),
        .q_y          (q_y),
        .q_z          (q_z),
        .r_x          (r_x),
        .r_y          (r_y),
        .r_z          (r_z),
        .valid        (valid),
        .q_bit        (q_bit),
        .r_bit        (r_bit),
        .code         (code),
        .b            (b),
        .terminate    (terminate),
        .done         (done),
`ifdef BSER_STALL_EN
        .stall        (stall),
`endif
        .ref_selected (ref_selected),
        .ref_pruned   (ref_pruned),
        .busy         (busy)
    );

    // pt[0..2] = query x,y,z; pt[3..5] = reference x,y,z
    typedef struct {
        logic [5:0][B-1:0] pt;
        int                term_k;    // stream index where terminate is raised, -1 = none
        int                done_wait; // idle cycles in WAIT_DONE before done
        bit                both;      // raise terminate together with done
        bit                exp_pruned;
        int                stall_k;   // stream index where a 5-cycle stall starts, -1 = none
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [B-1:0] qx, qy, qz, rx, ry, rz,
                                input int term_k, done_wait, input bit both,
                                input bit exp_pruned, input int stall_k);
        vec_t v;
        v.pt[0] = qx; v.pt[1] = qy; v.pt[2] = qz;
        v.pt[3] = rx; v.pt[4] = ry; v.pt[5] = rz;
        v.term_k = term_k; v.done_wait = done_wait; v.both = both;
        v.exp_pruned = exp_pruned; v.stall_k = stall_k;
        return v;
    endfunction

    task automatic check_result(input string tag, input bit exp_pruned);
        chk({tag, "_pruned"},   int'(ref_pruned),   int'(exp_pruned));
        chk({tag, "_selected"}, int'(ref_selected), int'(!exp_pruned));
        chk({tag, "_valid0"},   int'(valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_busy0"},    int'(busy), 0);
        step();
        chk({tag, "_pulse_end"}, int'(ref_pruned | ref_selected), 0);
    endtask

    task automatic run_point(input int idx, input vec_t v);
        int w;
        int p;
        int d;
        int nvalid;
        w = 0;
        nvalid = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk("in_ready_before_load", int'(in_ready), 1);
        q_x = v.pt[0]; q_y = v.pt[1]; q_z = v.pt[2];
        r_x = v.pt[3]; r_y = v.pt[4]; r_z = v.pt[5];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef BSER_STALL_EN
            if (k == v.stall_k) begin
                for (int s = 0; s < 5; s++) begin
                    stall = 1'b1;
                    #1;
                    chk("stall_valid0", int'(valid), 0);
                    chk("stall_code0", int'(code), 0);
                    @(posedge clk);
                    #1;
                end
                stall = 1'b0;
                #1;
            end
`endif
            p = k / 3;
            d = k % 3;
            chk("valid", int'(valid), 1);
            chk("q_bit", int'(q_bit), int'(v.pt[d][B-1-p]));
            chk("r_bit", int'(r_bit), int'(v.pt[d+3][B-1-p]));
            chk("code", int'(code), d + 1);
            chk("b", int'(b), (p + 1) % B);
            chk("in_ready_stream", int'(in_ready), 0);
            if (valid) nvalid++;
            if (k == v.term_k) begin
                terminate = 1'b1;
                done = v.both;
                step();
                terminate = 1'b0;
                done = 1'b0;
                $display("point %0d: terminated at k=%0d", idx, k);
                check_result("term", v.exp_pruned);
                return;
            end
            step();
        end
        chk("valid_count", nvalid, N);
        for (int i = 0; i < v.done_wait; i++) begin
            chk("wait_valid0", int'(valid), 0);
            chk("wait_bits0", int'({q_bit, r_bit, code, b}), 0);
            chk("wait_busy", int'(busy), 1);
            chk("wait_in_ready0", int'(in_ready), 0);
            chk("wait_no_pulse", int'(ref_pruned | ref_selected), 0);
            step();
        end
        chk("wait_valid0", int'(valid), 0);
        done = 1'b1;
        terminate = v.both;
        step();
        done = 1'b0;
        terminate = 1'b0;
        $display("point %0d: full stream, done after %0d, both=%0d", idx, v.done_wait, v.both);
        check_result("done", v.exp_pruned);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = mk(32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, -1, 0, 1'b0, 1'b0, 20);
        tbl[1] = mk(32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 32'h80000001, 32'hFFFF0000, 32'h55AA55AA, 10, 0, 1'b0, 1'b1, -1);
        tbl[2] = mk(32'hA5A5A5A5, 32'h3C3C3C3C, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'hCAFEF00D, -1, 2, 1'b0, 1'b0, -1);
        tbl[3] = mk(32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888, 32'h01234567, 32'h89ABCDEF, -1, 1, 1'b1, 1'b1, -1);
        tbl[4] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, N-1, 0, 1'b0, 1'b1, -1);
        tbl[5] = mk(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, -1);
        tbl[6] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 3, 1'b0, 1'b0, -1);

        // reset state
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'(ref_pruned | ref_selected), 0);
        rst = 1'b1;
        step();
        $display("reset released");

        for (int i = 0; i < 7; i++) run_point(i, tbl[i]);

        // reset in the middle of a stream
        q_x = 32'h12345678; q_y = 32'h9ABCDEF0; q_z = 32'h0; r_x = 32'h1; r_y = 32'h2; r_z = 32'h3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) step();
        chk("pre_rst_valid", int'(valid), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_valid0", int'(valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy0", int'(busy), 0);
        chk("midrst_no_pulse", int'(ref_pruned | ref_selected), 0);
        step();
        chk("midrst_no_pulse2", int'(ref_pruned | ref_selected), 0);
        $display("reset mid-stream at k=40");

        // terminate/done while idle must do nothing
        terminate = 1'b1;
        done = 1'b1;
        step();
        terminate = 1'b0;
        done = 1'b0;
        chk("idle_term_no_pulse", int'(ref_pruned | ref_selected), 0);
        chk("idle_term_busy0", int'(busy), 0);
        step();
        chk("idle_term_no_pulse2", int'(ref_pruned | ref_selected), 0);
        $display("terminate+done in IDLE ignored");

        for (int i = 0; i < 15; i++) begin
            rv = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N-1)) : -1,
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N-1)) : -1);
            rv.exp_pruned = (rv.term_k >= 0) || rv.both;
            run_point(100 + i, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
